// File: rtl/if_cache_pkg.sv
// Shared widths, geometry and FSM encodings for the instruction cache.
package if_cache_pkg;

    localparam logic RST_ENABLE    = 1'b1;
    localparam int   INST_ADDR_W   = 32;
    localparam int   INST_W        = 32;
    localparam int   ICACHE_LINES  = 32;
    localparam int   ICACHE_IDX_W  = 5;
    localparam int   ICACHE_TAG_W  = 23;
    localparam int   ICACHE_WORD_W = 2;
    localparam int   ICACHE_RAM_AW = ICACHE_IDX_W + ICACHE_WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_DONE   = 2'd2
    } ic_state_e;

    function automatic logic [ICACHE_RAM_AW-1:0] ram_addr(
        input logic [ICACHE_IDX_W-1:0]  idx,
        input logic [ICACHE_WORD_W-1:0] word
    );
        return {idx, word};
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// 128x32 line-data store: one synchronous write port, one async read port.
import if_cache_pkg::*;

module icache_data_ram (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [ICACHE_RAM_AW-1:0] waddr_i,
    input  logic [INST_W-1:0]        wdata_i,
    input  logic [ICACHE_RAM_AW-1:0] raddr_i,
    output logic [INST_W-1:0]        rdata_o
);

    logic [INST_W-1:0] mem [ICACHE_LINES*4];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/if_cache.sv
// Direct-mapped 32x16B instruction cache with zero-latency hit path
// and a 4-word in-order refill FSM.
import if_cache_pkg::*;

module if_cache (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic        stallreq_o,
    output logic        mem_ce_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    ic_state_e                state_q, state_d;
    logic [ICACHE_WORD_W-1:0] cnt_q, cnt_d;
    logic [ICACHE_TAG_W-1:0]  ltag_q, ltag_d;
    logic [ICACHE_IDX_W-1:0]  lidx_q, lidx_d;
    logic [ICACHE_LINES-1:0]  valid_q, valid_d;

    logic [ICACHE_TAG_W-1:0]  tag_arr [ICACHE_LINES];

    logic [ICACHE_TAG_W-1:0]  pc_tag;
    logic [ICACHE_IDX_W-1:0]  pc_idx;
    logic [ICACHE_WORD_W-1:0] pc_off;
    logic                     in_rst;
    logic                     hit;
    logic                     miss;
    logic                     ram_we;
    logic                     tag_we;
    logic [INST_W-1:0]        ram_rdata;

    assign pc_tag = pc_i[31:9];
    assign pc_idx = pc_i[8:4];
    assign pc_off = pc_i[3:2];
    assign in_rst = (rst == RST_ENABLE);

    assign hit = !in_rst && ce_i && valid_q[pc_idx]
              && (tag_arr[pc_idx] == pc_tag)
              && (state_q == ST_IDLE);

    assign miss = !in_rst && ce_i && !hit
               && (state_q == ST_IDLE);

    // Array writes are suppressed on flush/reset so aborted lines stay clean.
    assign ram_we = !in_rst && !flush_i && mem_ack_i
                 && (state_q == ST_REFILL);

    assign tag_we = !in_rst && !flush_i
                 && (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ltag_d  = ltag_q;
        lidx_d  = lidx_q;
        valid_d = valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    valid_d = '0;
                end else if (miss) begin
                    ltag_d  = pc_tag;
                    lidx_d  = pc_idx;
                    cnt_d   = '0;
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (flush_i) begin
                    valid_d = '0;
                    state_d = ST_IDLE;
                end else if (mem_ack_i) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (flush_i) begin
                    valid_d = '0;
                end else begin
                    valid_d[lidx_q] = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ltag_q  <= '0;
            lidx_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ltag_q  <= ltag_d;
            lidx_q  <= lidx_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_arr[lidx_q] <= ltag_q;
        end
    end

    icache_data_ram u_data_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_addr(lidx_q, cnt_q)),
        .wdata_i (mem_data_i),
        .raddr_i (ram_addr(pc_idx, pc_off)),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        stallreq_o = 1'b0;
        mem_ce_o   = 1'b0;
        mem_addr_o = 32'h0;
        inst_o     = 32'h0;
        if (!in_rst) begin
            stallreq_o = miss || (state_q != ST_IDLE);
            mem_ce_o   = (state_q == ST_REFILL);
            if (mem_ce_o) begin
                mem_addr_o = {ltag_q, lidx_q, cnt_q, 2'b00};
            end
            if (hit) begin
                inst_o = ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_if_cache.sv
// Directed self-checking bench for if_cache: vector table plus
// hand-written refill, flush and reset sequences.
module tb_if_cache;

    logic        clk;
    logic        rst;
    logic        ce_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic [31:0] inst_o;
    logic        stallreq_o;
    logic        mem_ce_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        mem_ack_i;

    int total = 0;
    int bad = 0;
    int stall_cnt = 0;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic        ack;
        logic [31:0] inst;
        logic        stall;
    } vec_t;

    vec_t vecs [6];

    if_cache dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .pc_i       (pc_i),
        .flush_i    (flush_i),
        .inst_o     (inst_o),
        .stallreq_o (stallreq_o),
        .mem_ce_o   (mem_ce_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic miss_cycle(input logic [31:0] pc);
        pc_i = pc;
        ce_i = 1'b1;
        flush_i = 1'b0;
        mem_ack_i = 1'b0;
        #1;
        chk("miss_stall", {31'h0, stallreq_o}, 32'h1);
        chk("miss_mce", {31'h0, mem_ce_o}, 32'h0);
        chk("miss_inst", inst_o, 32'h0);
        stall_cnt = int'(stallreq_o);
        @(negedge clk);
    endtask

    task automatic ref_check(input logic [31:0] addr);
        #1;
        chk("ref_stall", {31'h0, stallreq_o}, 32'h1);
        chk("ref_mce", {31'h0, mem_ce_o}, 32'h1);
        chk("ref_addr", mem_addr_o, addr);
        chk("ref_inst", inst_o, 32'h0);
        stall_cnt += int'(stallreq_o);
        @(negedge clk);
    endtask

    task automatic word(input logic [31:0] addr, input logic [31:0] data,
                        input int gap, input bit toggle);
        for (int g = 0; g < gap; g++) begin
            mem_ack_i = 1'b0;
            mem_data_i = 32'hDEAD_BEEF;
            if (toggle) pc_i = (g % 2 == 0) ? 32'h40 : 32'h1234;
            ref_check(addr);
        end
        mem_ack_i = 1'b1;
        mem_data_i = data;
        ref_check(addr);
        mem_ack_i = 1'b0;
    endtask

    task automatic done_cycle;
        mem_ack_i = 1'b0;
        #1;
        chk("done_stall", {31'h0, stallreq_o}, 32'h1);
        chk("done_mce", {31'h0, mem_ce_o}, 32'h0);
        chk("done_addr", mem_addr_o, 32'h0);
        stall_cnt += int'(stallreq_o);
        @(negedge clk);
    endtask

    task automatic hit(input logic [31:0] pc, input logic [31:0] exp);
        pc_i = pc;
        ce_i = 1'b1;
        flush_i = 1'b0;
        #1;
        chk("hit_inst", inst_o, exp);
        chk("hit_stall", {31'h0, stallreq_o}, 32'h0);
        chk("hit_mce", {31'h0, mem_ce_o}, 32'h0);
        @(negedge clk);
    endtask

    task automatic refill(input logic [31:0] pc, input logic [31:0] base,
                          input int gap, input bit toggle);
        logic [31:0] line;
        line = {pc[31:4], 4'h0};
        miss_cycle(pc);
        for (int w = 0; w < 4; w++) begin
            word(line + 32'(4 * w), base + 32'(w), gap, toggle);
        end
        done_cycle();
        hit(pc, base + 32'(pc[3:2]));
    endtask

    initial begin
        rst = 1'b1;
        ce_i = 1'b1;
        pc_i = 32'h40;
        flush_i = 1'b0;
        mem_ack_i = 1'b0;
        mem_data_i = 32'h0;
        #1;
        chk("rst_stall", {31'h0, stallreq_o}, 32'h0);
        chk("rst_mce", {31'h0, mem_ce_o}, 32'h0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        refill(32'h40, 32'hA0, 0, 1'b0);
        chk("cold_stall_cycles", 32'(stall_cnt), 32'd6);

        vecs[0] = '{32'h44, 1'b1, 1'b0, 32'hA1, 1'b0};
        vecs[1] = '{32'h48, 1'b1, 1'b1, 32'hA2, 1'b0};
        vecs[2] = '{32'h4C, 1'b1, 1'b0, 32'hA3, 1'b0};
        vecs[3] = '{32'h43, 1'b1, 1'b1, 32'hA0, 1'b0};
        vecs[4] = '{32'h40, 1'b0, 1'b0, 32'h00, 1'b0};
        vecs[5] = '{32'h4C, 1'b1, 1'b0, 32'hA3, 1'b0};
        for (int i = 0; i < 6; i++) begin
            pc_i = vecs[i].pc;
            ce_i = vecs[i].ce;
            mem_ack_i = vecs[i].ack;
            mem_data_i = 32'hBAD0_0000;
            #1;
            chk($sformatf("vec%0d_inst", i), inst_o, vecs[i].inst);
            chk($sformatf("vec%0d_stall", i), {31'h0, stallreq_o},
                {31'h0, vecs[i].stall});
            chk($sformatf("vec%0d_mce", i), {31'h0, mem_ce_o}, 32'h0);
            chk($sformatf("vec%0d_addr", i), mem_addr_o, 32'h0);
            @(negedge clk);
        end
        mem_ack_i = 1'b0;

        refill(32'h240, 32'hB0, 0, 1'b0);
        hit(32'h24C, 32'hB3);
        refill(32'h40, 32'hA0, 0, 1'b0);

        refill(32'h80, 32'hC0, 3, 1'b1);
        chk("slow_stall_cycles", 32'(stall_cnt), 32'd18);
        hit(32'h88, 32'hC2);
        hit(32'h44, 32'hA1);

        miss_cycle(32'hC0);
        word(32'hC0, 32'hE0, 0, 1'b0);
        word(32'hC4, 32'hE1, 0, 1'b0);
        flush_i = 1'b1;
        #1;
        chk("flush_ref_stall", {31'h0, stallreq_o}, 32'h1);
        @(negedge clk);
        flush_i = 1'b0;
        ce_i = 1'b0;
        #1;
        chk("flush_after_mce", {31'h0, mem_ce_o}, 32'h0);
        chk("flush_after_stall", {31'h0, stallreq_o}, 32'h0);
        @(negedge clk);
        refill(32'h40, 32'hD0, 0, 1'b0);

        pc_i = 32'h300;
        ce_i = 1'b1;
        flush_i = 1'b1;
        #1;
        chk("flush_miss_stall", {31'h0, stallreq_o}, 32'h1);
        @(negedge clk);
        flush_i = 1'b0;
        ce_i = 1'b0;
        #1;
        chk("flush_miss_mce", {31'h0, mem_ce_o}, 32'h0);
        @(negedge clk);

        miss_cycle(32'h40);
        word(32'h40, 32'hF0, 0, 1'b0);
        word(32'h44, 32'hF1, 0, 1'b0);
        rst = 1'b1;
        mem_ack_i = 1'b1;
        mem_data_i = 32'hF2;
        #1;
        chk("midrst_stall", {31'h0, stallreq_o}, 32'h0);
        chk("midrst_mce", {31'h0, mem_ce_o}, 32'h0);
        chk("midrst_addr", mem_addr_o, 32'h0);
        chk("midrst_inst", inst_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack_i = 1'b0;
        refill(32'h44, 32'h50, 0, 1'b0);
        hit(32'h4C, 32'h53);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
